// File: rtl/booth_ctrl_fsm_if.sv
// Handshake/strobe bundle between the Booth controller and its datapath.
// The controller sits on the slave side; the datapath (or a bench) drives the master side.
interface booth_ctrl_fsm_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic          i_start;
  logic          i_q0;
  logic          i_qm1;
  logic          o_ld_m;
  logic          o_ld_q;
  logic          o_ld_acc;
  logic [1:0]    o_acc_sel;
  logic          o_shift_q;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_count;

  modport master (
    output i_start, i_q0, i_qm1,
    input  o_ld_m, o_ld_q, o_ld_acc, o_acc_sel, o_shift_q, o_busy, o_done, o_count
  );

  modport slave (
    input  i_start, i_q0, i_qm1,
    output o_ld_m, o_ld_q, o_ld_acc, o_acc_sel, o_shift_q, o_busy, o_done, o_count
  );
endinterface

// File: rtl/booth_ctrl_fsm.sv
// Radix-2 Booth multiplier sequencer: IDLE -> INIT -> WIDTH x ITER -> DONE -> IDLE.
// Strobes are registered alongside the one-hot state; only the ITER mux select is combinational.
module booth_ctrl_fsm #(
  parameter int WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  booth_ctrl_fsm_if.slave       bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_INIT = 4'b0010,
    S_ITER = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  state_e        state_q;
  logic          ld_m_q;
  logic          ld_q_q;
  logic          ld_acc_q;
  logic          shift_q_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] count_q;
  logic [1:0]    acc_sel_s;

  // State register and registered strobes; strobes are set for the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ld_m_q    <= 1'b0;
      ld_q_q    <= 1'b0;
      ld_acc_q  <= 1'b0;
      shift_q_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= {CW{1'b0}};
    end else begin
      ld_m_q    <= 1'b0;
      ld_q_q    <= 1'b0;
      ld_acc_q  <= 1'b0;
      shift_q_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            state_q  <= S_INIT;
            ld_m_q   <= 1'b1;
            ld_q_q   <= 1'b1;
            ld_acc_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_INIT: begin
          state_q   <= S_ITER;
          ld_acc_q  <= 1'b1;
          shift_q_q <= 1'b1;
          busy_q    <= 1'b1;
          count_q   <= CW'(WIDTH);
        end
        S_ITER: begin
          count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
          if (count_q == {{(CW-1){1'b0}}, 1'b1}) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_ITER;
            ld_acc_q  <= 1'b1;
            shift_q_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          // Corrupted encoding: drop back to a clean idle with no pending count.
          state_q <= S_IDLE;
          count_q <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Booth recoding of {Q0,Q-1}: equal bits pass A, 01 adds M, 10 subtracts M.
  always_comb begin
    acc_sel_s = 2'b00;
    if (state_q == S_ITER) begin
      case ({bus.i_q0, bus.i_qm1})
        2'b01:   acc_sel_s = 2'b10;
        2'b10:   acc_sel_s = 2'b11;
        default: acc_sel_s = 2'b01;
      endcase
    end else begin
      acc_sel_s = 2'b00;
    end
  end

  assign bus.o_ld_m    = ld_m_q;
  assign bus.o_ld_q    = ld_q_q;
  assign bus.o_ld_acc  = ld_acc_q;
  assign bus.o_acc_sel = acc_sel_s;
  assign bus.o_shift_q = shift_q_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_count   = count_q;
endmodule
